// File: rtl/huffman_priority_queue.sv
// Sorted slot array (ascending frequency) between the frequency counter and the Huffman tree builder.
// Define HUFFMAN_PQ_POP2_EN to expose slot[1] (next_*) and a single-cycle two-entry pop (pop2_req).
module huffman_priority_queue #(
    parameter int DEPTH  = 16,
    parameter int SYM_W  = 9,
    parameter int FREQ_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              ctrl_reset,
    input  logic              ctrl_clear,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [SYM_W-1:0]  ins_sym,
    input  logic              ins_leaf,
    input  logic [FREQ_W-1:0] ins_freq,
    input  logic              pop_req,
    output logic              head_valid,
    output logic [SYM_W-1:0]  head_sym,
    output logic              head_leaf,
    output logic [FREQ_W-1:0] head_freq,
`ifdef HUFFMAN_PQ_POP2_EN
    input  logic              pop2_req,
    output logic              next_valid,
    output logic [SYM_W-1:0]  next_sym,
    output logic              next_leaf,
    output logic [FREQ_W-1:0] next_freq,
`endif
    output logic [CNT_W-1:0]  count,
    output logic              underflow
);
    typedef struct packed {
        logic              vld;
        logic [SYM_W-1:0]  sym;
        logic              leaf;
        logic [FREQ_W-1:0] freq;
    } slot_t;

    slot_t [DEPTH-1:0] slots, slotsNxt, shifted, below;
    slot_t [DEPTH+1:0] ext;
    slot_t             newEntry;
    logic  [DEPTH+1:0] le;
    logic  [DEPTH-1:0] leS, leBelow;
    logic  [1:0]       shiftAmt;
    logic              insFire, popFire, underflowSet;

    assign ins_ready = (count != CNT_W'(DEPTH));
    assign insFire   = ins_valid && ins_ready;
    assign popFire   = pop_req && (count != '0);
    assign newEntry  = '{vld: 1'b1, sym: ins_sym, leaf: ins_leaf, freq: ins_freq};

`ifdef HUFFMAN_PQ_POP2_EN
    logic pop2Fire;
    assign pop2Fire     = pop2_req && (count >= CNT_W'(2));
    assign shiftAmt     = pop2Fire ? 2'd2 : (popFire ? 2'd1 : 2'd0);
    assign underflowSet = pop2_req ? (count < CNT_W'(2)) : (pop_req && (count == '0));
    assign next_valid   = (count >= CNT_W'(2));
    assign next_sym     = slots[1].sym;
    assign next_leaf    = slots[1].leaf;
    assign next_freq    = slots[1].freq;
`else
    assign shiftAmt     = {1'b0, popFire};
    assign underflowSet = pop_req && (count == '0);
`endif

    assign head_valid = slots[0].vld;
    assign head_sym   = slots[0].sym;
    assign head_leaf  = slots[0].leaf;
    assign head_freq  = slots[0].freq;

    // Pop is a shift down by shiftAmt; a same-cycle insert then lands stably in the shifted view.
    // le is a contiguous prefix because valid slots are contiguous and sorted.
    always_comb begin
        ext = '0;
        ext[DEPTH-1:0] = slots;
        for (int i = 0; i < DEPTH + 2; i++)
            le[i] = ext[i].vld && (ext[i].freq <= ins_freq);
        for (int i = 0; i < DEPTH; i++) begin
            shifted[i] = ext[i + int'(shiftAmt)];
            leS[i]     = le[i + int'(shiftAmt)];
        end
        below      = '0;
        leBelow    = '0;
        leBelow[0] = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            below[i]   = shifted[i-1];
            leBelow[i] = leS[i-1];
        end
        slotsNxt = shifted;
        if (insFire) begin
            for (int i = 0; i < DEPTH; i++)
                if (!leS[i])
                    slotsNxt[i] = leBelow[i] ? newEntry : below[i];
        end
    end

    always_ff @(posedge clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            slots     <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else if (ctrl_clear) begin
            slots     <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            slots <= slotsNxt;
            count <= count + CNT_W'(insFire) - CNT_W'(shiftAmt);
            if (underflowSet)
                underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_huffman_priority_queue.sv
// Directed bench for huffman_priority_queue; expected values are hand-derived from the queue ordering rules.
module tb_huffman_priority_queue;
    localparam int DEPTH  = 16;
    localparam int SYM_W  = 9;
    localparam int FREQ_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              ctrl_reset = 1'b1;
    logic              ctrl_clear = 1'b0;
    logic              ins_valid = 1'b0;
    logic              ins_ready;
    logic [SYM_W-1:0]  ins_sym = '0;
    logic              ins_leaf = 1'b0;
    logic [FREQ_W-1:0] ins_freq = '0;
    logic              pop_req = 1'b0;
    logic              head_valid;
    logic [SYM_W-1:0]  head_sym;
    logic              head_leaf;
    logic [FREQ_W-1:0] head_freq;
`ifdef HUFFMAN_PQ_POP2_EN
    logic              pop2_req = 1'b0;
    logic              next_valid;
    logic [SYM_W-1:0]  next_sym;
    logic              next_leaf;
    logic [FREQ_W-1:0] next_freq;
`endif
    logic [CNT_W-1:0]  count;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    huffman_priority_queue #(.DEPTH(DEPTH), .SYM_W(SYM_W), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .ctrl_reset(ctrl_reset), .ctrl_clear(ctrl_clear),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_sym(ins_sym),
        .ins_leaf(ins_leaf), .ins_freq(ins_freq), .pop_req(pop_req),
        .head_valid(head_valid), .head_sym(head_sym), .head_leaf(head_leaf),
        .head_freq(head_freq),
`ifdef HUFFMAN_PQ_POP2_EN
        .pop2_req(pop2_req), .next_valid(next_valid), .next_sym(next_sym),
        .next_leaf(next_leaf), .next_freq(next_freq),
`endif
        .count(count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sym, input int freq);
        ins_valid = 1'b1;
        ins_sym   = SYM_W'(sym);
        ins_leaf  = 1'b1;
        ins_freq  = FREQ_W'(freq);
        step();
        ins_valid = 1'b0;
    endtask

    task automatic clearQ();
        ctrl_clear = 1'b1;
        step();
        ctrl_clear = 1'b0;
    endtask

    int expSym[4] = '{'h62, 'h64, 'h61, 'h63};
    int expFreq[4] = '{2, 2, 5, 9};

    initial begin
        #3;
        chk("rst_head_valid", head_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ins_ready", ins_ready, 1);
        chk("rst_underflow", underflow, 0);
        chk("rst_head_freq", head_freq, 0);
        chk("rst_head_sym", head_sym, 0);
        #9 ctrl_reset = 1'b0;

        // Stable sort: b(2) d(2) a(5) c(9)
        push('h61, 5);
        push('h62, 2);
        push('h63, 9);
        push('h64, 2);
        chk("sort_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop_head_sym%0d", i), head_sym, expSym[i]);
            chk($sformatf("pop_head_freq%0d", i), head_freq, expFreq[i]);
            pop_req = 1'b1;
            step();
        end
        chk("empty_head_valid", head_valid, 0);
        chk("empty_count", count, 0);
        chk("empty_underflow", underflow, 0);
        step();
        pop_req = 1'b0;
        chk("underflow_set", underflow, 1);
        chk("underflow_count", count, 0);
        step();
        chk("underflow_sticky", underflow, 1);
        clearQ();
        chk("clear_underflow", underflow, 0);

        // Fill to DEPTH, then hold a blocked insert
        for (int i = 1; i <= DEPTH; i++) push(i, i);
        chk("full_count", count, DEPTH);
        chk("full_ready", ins_ready, 0);
        ins_valid = 1'b1; ins_sym = SYM_W'(99); ins_freq = '0;
        step();
        chk("blocked_count", count, DEPTH);
        chk("blocked_head", head_freq, 1);
        chk("blocked_underflow", underflow, 0);
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        chk("full_pop_count", count, DEPTH - 1);
        chk("full_pop_head", head_freq, 2);
        step();
        ins_valid = 1'b0;
        chk("late_ins_count", count, DEPTH);
        chk("late_ins_head", head_freq, 0);
        chk("late_ins_sym", head_sym, 99);
        clearQ();

        // Combined insert + pop
        push(1, 3); push(2, 7); push(3, 10);
        ins_valid = 1'b1; ins_sym = SYM_W'(4); ins_freq = 8; pop_req = 1'b1;
        step();
        chk("combo_head", head_freq, 7);
        chk("combo_count", count, 3);
        ins_sym = SYM_W'(5); ins_freq = 1;
        step();
        ins_valid = 1'b0;
        chk("combo2_head", head_freq, 1);
        chk("combo2_sym", head_sym, 5);
        chk("combo2_count", count, 3);
        step();
        chk("combo_mid", head_freq, 8);
        step();
        pop_req = 1'b0;
        chk("combo_top", head_freq, 10);
        chk("combo_top_count", count, 1);
        clearQ();

        // Clear beats same-cycle insert and pop
        pop_req = 1'b1; step(); pop_req = 1'b0;
        for (int i = 0; i < 5; i++) push(i, 20 - i);
        chk("pre_clear_count", count, 5);
        chk("pre_clear_underflow", underflow, 1);
        ctrl_clear = 1'b1; ins_valid = 1'b1; pop_req = 1'b1; ins_freq = 4;
        step();
        ctrl_clear = 1'b0; ins_valid = 1'b0; pop_req = 1'b0;
        chk("clear_count", count, 0);
        chk("clear_head_valid", head_valid, 0);
        chk("clear_underflow2", underflow, 0);

        // Asynchronous reset between edges
        push(1, 6); push(2, 4);
        chk("pre_async_count", count, 2);
        #2 ctrl_reset = 1'b1;
        #1;
        chk("async_count", count, 0);
        chk("async_head_valid", head_valid, 0);
        chk("async_head_freq", head_freq, 0);
        #1 ctrl_reset = 1'b0;

`ifdef HUFFMAN_PQ_POP2_EN
        step();
        push(1, 4); push(2, 6); push(3, 9);
        chk("p2_next_freq0", next_freq, 6);
        pop2_req = 1'b1; ins_valid = 1'b1; ins_sym = SYM_W'(7); ins_freq = 10;
        step();
        pop2_req = 1'b0; ins_valid = 1'b0;
        chk("p2_head", head_freq, 9);
        chk("p2_next", next_freq, 10);
        chk("p2_next_valid", next_valid, 1);
        chk("p2_count", count, 2);
        chk("p2_underflow", underflow, 0);
        pop_req = 1'b1; step(); pop_req = 1'b0;
        pop2_req = 1'b1; step(); pop2_req = 1'b0;
        chk("p2_short_count", count, 1);
        chk("p2_short_underflow", underflow, 1);
        chk("p2_short_next_valid", next_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/huffman_priority_queue.md
Name: huffman_priority_queue

Overview:
- Parametrised successor to the single queue slot: an array of DEPTH slots kept sorted ascending by frequency, with single-cycle insert, pop-min and combined insert+pop.
- Each slot holds {symbol/node id, leaf flag, frequency}.
- Sits between the frequency counter and the tree builder. The builder repeatedly pops the two lowest entries and re-inserts their merged node.

Parameters:
DEPTH, 16, number of slots (≥2)
SYM_W, 9, symbol/node id width (8-bit ASCII leaves plus internal node ids)
FREQ_W, 32, frequency width
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock
ctrl_reset  in  1  asynchronous active-high reset
ctrl_clear  in  1  synchronous clear; empties the queue
ins_valid  in  1  insert request
ins_ready  out  1  high when count != DEPTH
ins_sym  in  SYM_W  symbol/node id to insert
ins_leaf  in  1  1 = leaf, 0 = internal node
ins_freq  in  FREQ_W  frequency key
pop_req  in  1  remove the head entry
head_valid  out  1  queue non-empty
head_sym  out  SYM_W  symbol/node id of the minimum entry
head_leaf  out  1  leaf flag of the minimum entry
head_freq  out  FREQ_W  frequency of the minimum entry
count  out  CNT_W  number of valid entries
underflow  out  1  sticky; set when pop_req arrives while empty

Behaviour:
- Clock and reset: one clock, clk. Reset ctrl_reset is asynchronous and active-high.
- Reset values: all slot valid bits 0, slot contents 0, count 0, underflow 0. Therefore head_valid 0, head_sym 0, head_leaf 0, head_freq 0, ins_ready 1.
- Storage order: slot[0] is the minimum; valid slots are contiguous from slot 0. head_* is taken directly from slot[0] (registered).
- Latency: any operation is visible on head_*/count the cycle after the fire edge.
- Fire conditions: ins_fire = ins_valid & ins_ready; pop_fire = pop_req & (count != 0).
- Insert position: p = number of valid entries with freq <= ins_freq, computed as a parallel compare of every slot. Ties are stable: the new entry goes after existing equal-frequency entries.
- Insert only: slots[p..DEPTH-2] shift up by one; slot[p] takes the new entry; count += 1.
- Pop only: every slot takes slot[i+1]; the top slot is loaded with zeros and marked invalid; count -= 1.
- Insert + pop, same cycle:
  - Result equals popping slot[0] and then stably inserting the new entry. Count is unchanged.
  - If p == 0, the new entry becomes slot[0].
  - Otherwise slots[1..p-1] shift down, the new entry lands in slot[p-1], and slots ≥ p are unchanged.
  - Allowed only when not full, because ins_ready depends only on count (no combinational ready-from-pop path).
- pop_req while empty: ignored, contents unchanged, underflow set to 1. underflow is cleared only by reset or ctrl_clear.
- ins_valid while full: ins_ready = 0, so no fire. The producer holds its data; nothing is dropped and no flag is raised.
- ctrl_clear: has priority over insert and pop in the same cycle. Next cycle: all slots invalid and zero, count 0, underflow 0.
- Reset asserted mid-operation: immediate clear regardless of clk; the in-flight op is lost.
- Frequency compare is unsigned over FREQ_W. There is no arithmetic in this block; merge sums are produced by the builder.

Optional Feature:
- Macro: HUFFMAN_PQ_POP2_EN.
- With the macro defined, the following ports are added:
  - next_valid (out, 1): count ≥ 2.
  - next_sym, next_leaf, next_freq (out): contents of slot[1].
  - pop2_req (in, 1): removes slot[0] and slot[1] in one cycle (shift down by two; count -= 2). It may combine with an insert; the result equals pop2 followed by a stable insert.
  - pop2_req with count < 2: ignored and underflow set.
  - pop_req together with pop2_req: pop2 wins.
- Without the macro: these ports are absent, and the builder performs two single pops.

Test Plan:
- Reset then insert freqs 5, 2, 9, 2 (syms 'a', 'b', 'c', 'd') → order b(2), d(2), a(5), c(9); head_sym = 'b'; count = 4.
- Pop four times then a fifth pop → heads b, d, a, c on successive cycles. After the fifth pop: head_valid 0, count 0, underflow 1.
- Fill to DEPTH with freqs 1..16, hold ins_valid with freq 0 → ins_ready 0, contents unchanged. After one pop, the insert fires and head_freq = 0.
- Queue {3, 7, 10}; insert freq 8 with pop same cycle → {7, 8, 10}, count 3. Repeat with insert freq 1 → head_freq = 1, count unchanged.
- Assert ctrl_clear together with ins_valid and pop_req on a 5-entry queue → count 0, head_valid 0, underflow 0. Assert ctrl_reset asynchronously mid-stream → outputs clear before the next clk edge.
- HUFFMAN_PQ_POP2_EN: queue {4, 6, 9}; pop2 plus insert freq 10 → next cycle {9, 10}, head_freq 9, next_freq 10, count 2.
